fix_ari_acc: RTL and testbench

- Downstream stage of the fixed-point multiplier: accumulates a stream of full-width signed products (Q(2*INTE+1).(2*POIN)) over one vector.
- On the vector's last beat, rounds the sum back to the data format (sign + INTE integer + POIN fraction bits) and saturates it.
- Presents the result on a valid/ready output. It is the dot-product / MAC tail of the fixed-point arithmetic datapath.

---
 rtl/fix_ari_acc_if.sv | 38 +++
 rtl/fix_ari_acc.sv | 132 +++++++++++++
 tb/tb_fix_ari_acc.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fix_ari_acc_if.sv
`default_nettype none
// ============================================================================
//  Module      : fix_ari_acc_if
//  Description : Bus bundle for the fixed-point accumulate/round/saturate tail.
//                Carries the product input stream (prod_in, in_valid, in_last,
//                in_ready), the result output stream (data_out, out_valid,
//                out_ready, sat_flag) and the per-vector beat counter.
//                master : producer/consumer side (drives prod_in, in_valid,
//                         in_last, out_ready)
//                slave  : accumulator side (drives in_ready, data_out,
//                         out_valid, sat_flag, beat_cnt)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fix_ari_acc_if #(
  parameter int DATA  = 15,
  parameter int GUARD = 8
);
  logic [2*DATA-1:0] prod_in;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [DATA-1:0]   data_out;
  logic              out_valid;
  logic              out_ready;
  logic              sat_flag;
  logic [GUARD:0]    beat_cnt;

  modport master (
    output prod_in, in_valid, in_last, out_ready,
    input  in_ready, data_out, out_valid, sat_flag, beat_cnt
  );

  modport slave (
    input  prod_in, in_valid, in_last, out_ready,
    output in_ready, data_out, out_valid, sat_flag, beat_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fix_ari_acc.sv
`default_nettype none
// ============================================================================
//  Module      : fix_ari_acc
//  Description : Accumulates a vector of signed full-width products
//                (2*POIN fraction bits), then rounds half-up to POIN fraction
//                bits, saturates to the DATA-bit signed format and presents
//                the result on a valid/ready output.
//  Ports       : clk   - clock
//                rst_n - asynchronous active-low reset
//                bus   - fix_ari_acc_if.slave (product input stream, result
//                        output stream, sat_flag, beat_cnt)
//  Revision    : 1.0 - initial release
// ============================================================================
module fix_ari_acc #(
  parameter int DATA  = 15,
  parameter int INTE  = 6,
  parameter int POIN  = 8,
  parameter int GUARD = 8
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  fix_ari_acc_if.slave  bus
);

  localparam int ACC_W = 2*DATA + GUARD;
  localparam int OUT_W = 1 + INTE + POIN;
  localparam int R_W   = ACC_W - POIN;

  // Half an output LSB, expressed at input (2*POIN) precision.
  localparam logic signed [ACC_W-1:0] C_RND  = {{(ACC_W-POIN){1'b0}}, 1'b1, {(POIN-1){1'b0}}};
  localparam logic signed [R_W-1:0]   C_RMAX = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  // Two's-complement most-negative value is the bitwise inverse of the max.
  localparam logic signed [R_W-1:0]   C_RMIN = ~C_RMAX;
  localparam logic [GUARD:0]          C_CNT_LAST = {1'b0, {GUARD{1'b1}}};
  localparam logic [GUARD:0]          C_CNT_ONE  = {{GUARD{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic signed [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [GUARD:0]           r_cnt, w_cnt_nxt;
  logic [DATA-1:0]          r_data, w_data_nxt;
  logic                     r_sat, w_sat_nxt;

  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_sum_rnd;
  logic signed [R_W-1:0]    w_r;
  logic [DATA-1:0]          w_res;
  logic                     w_res_sat;
  logic                     w_accept;

  // Datapath: running sum including the current beat, rounded and clipped.
  always_comb begin
    w_prod_ext = {{(ACC_W-2*DATA){bus.prod_in[2*DATA-1]}}, bus.prod_in};
    w_sum      = r_acc + w_prod_ext;
    w_sum_rnd  = w_sum + C_RND;
    // Dropping the low POIN bits of a signed value is an arithmetic shift.
    w_r        = w_sum_rnd[ACC_W-1:POIN];
    if (w_r > C_RMAX) begin
      w_res     = C_RMAX[OUT_W-1:0];
      w_res_sat = 1'b1;
    end else if (w_r < C_RMIN) begin
      w_res     = C_RMIN[OUT_W-1:0];
      w_res_sat = 1'b1;
    end else begin
      w_res     = w_r[OUT_W-1:0];
      w_res_sat = 1'b0;
    end
  end

  assign w_accept = bus.in_valid && (r_state == ST_ACC);

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_sat_nxt   = r_sat;
    case (r_state)
      ST_ACC: begin
        if (w_accept) begin
          // The 2^GUARD-th beat closes the vector even without in_last so
          // the accumulator can never wrap.
          if (bus.in_last || (r_cnt == C_CNT_LAST)) begin
            w_data_nxt  = w_res;
            w_sat_nxt   = w_res_sat;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_OUT;
          end else begin
            w_acc_nxt = w_sum;
            w_cnt_nxt = r_cnt + C_CNT_ONE;
          end
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          w_state_nxt = ST_ACC;
        end
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_sat   <= w_sat_nxt;
    end
  end

  assign bus.in_ready  = (r_state == ST_ACC);
  assign bus.out_valid = (r_state == ST_OUT);
  assign bus.data_out  = r_data;
  assign bus.sat_flag  = r_sat;
  assign bus.beat_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fix_ari_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fix_ari_acc
//  Description : Directed self-checking bench for fix_ari_acc.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fix_ari_acc;

  localparam int DATA  = 15;
  localparam int INTE  = 6;
  localparam int POIN  = 8;
  localparam int GUARD = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fix_ari_acc_if #(.DATA(DATA), .GUARD(GUARD)) bus ();

  fix_ari_acc #(
    .DATA (DATA),
    .INTE (INTE),
    .POIN (POIN),
    .GUARD(GUARD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one beat; return 1 time unit after the edge that samples it.
  task automatic beat(input logic [2*DATA-1:0] p, input logic last);
    bus.prod_in  = p;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (bus.data_out !== 15'h0000) begin failures++; $display("FAIL reset_data_out got=%h want=0000", bus.data_out); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.sat_flag !== 1'b0) begin failures++; $display("FAIL reset_sat_flag got=%b want=0", bus.sat_flag); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.beat_cnt !== 9'd0) begin failures++; $display("FAIL reset_beat_cnt got=%0d want=0", bus.beat_cnt); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ordinary();
    beat(30'h0010000, 1'b0);
    beat(30'h0010000, 1'b0);
    checks++; if (bus.beat_cnt !== 9'd2) begin failures++; $display("FAIL ord_beat_cnt got=%0d want=2", bus.beat_cnt); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ord_early_valid got=%b want=0", bus.out_valid); end
    beat(30'h0010000, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ord_out_valid got=%b want=1", bus.out_valid); end
    checks++; if (bus.data_out !== 15'h0300) begin failures++; $display("FAIL ord_data got=%h want=0300", bus.data_out); end
    checks++; if (bus.sat_flag !== 1'b0) begin failures++; $display("FAIL ord_sat got=%b want=0", bus.sat_flag); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL ord_in_ready_low got=%b want=0", bus.in_ready); end
    step();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL ord_in_ready_back got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ord_out_valid_drop got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_rounding();
    logic [2*DATA-1:0] p_tab [4];
    logic [DATA-1:0]   e_tab [4];
    p_tab[0] = 30'h0000080;  e_tab[0] = 15'h0001;
    p_tab[1] = 30'h000007F;  e_tab[1] = 15'h0000;
    p_tab[2] = 30'h3FFFFF80; e_tab[2] = 15'h0000;
    p_tab[3] = 30'h3FFFFF7F; e_tab[3] = 15'h7FFF;
    for (int i = 0; i < 4; i++) begin
      beat(p_tab[i], 1'b1);
      checks++;
      if (bus.data_out !== e_tab[i] || bus.out_valid !== 1'b1 || bus.sat_flag !== 1'b0) begin
        failures++;
        $display("FAIL round_%0d got=%h v=%b s=%b want=%h v=1 s=0", i, bus.data_out, bus.out_valid, bus.sat_flag, e_tab[i]);
      end
      step();
    end
  endtask

  task automatic test_saturation();
    beat(30'h1FFFFFFF, 1'b0);
    beat(30'h1FFFFFFF, 1'b1);
    checks++; if (bus.data_out !== 15'h3FFF) begin failures++; $display("FAIL sat_pos_data got=%h want=3fff", bus.data_out); end
    checks++; if (bus.sat_flag !== 1'b1) begin failures++; $display("FAIL sat_pos_flag got=%b want=1", bus.sat_flag); end
    step();
    beat(30'h20000000, 1'b1);
    checks++; if (bus.data_out !== 15'h4000) begin failures++; $display("FAIL sat_neg_data got=%h want=4000", bus.data_out); end
    checks++; if (bus.sat_flag !== 1'b1) begin failures++; $display("FAIL sat_neg_flag got=%b want=1", bus.sat_flag); end
    step();
  endtask

  task automatic test_bubbles();
    // 1.0 + 0.5 + 0.25 = 1.75 -> 0x01C0
    beat(30'h0010000, 1'b0);
    bus.in_last = 1'b1;  // in_last without in_valid must be ignored
    step();
    bus.in_last = 1'b0;
    step();
    checks++; if (bus.beat_cnt !== 9'd1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL bub_hold got cnt=%0d v=%b want cnt=1 v=0", bus.beat_cnt, bus.out_valid); end
    beat(30'h0008000, 1'b0);
    step();
    beat(30'h0004000, 1'b1);
    checks++; if (bus.data_out !== 15'h01C0 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bub_data got=%h v=%b want=01c0 v=1", bus.data_out, bus.out_valid); end
    step();
  endtask

  task automatic test_back_to_back_stall();
    bus.out_ready = 1'b0;
    beat(30'h00A0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.prod_in  = 30'h0010000;
      bus.in_valid = 1'b1;
      bus.in_last  = 1'b1;
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.data_out !== 15'h0A00 || bus.in_ready !== 1'b0 || bus.beat_cnt !== 9'd0) begin
        failures++;
        $display("FAIL stall_%0d got v=%b d=%h rdy=%b cnt=%0d want v=1 d=0a00 rdy=0 cnt=0", i, bus.out_valid, bus.data_out, bus.in_ready, bus.beat_cnt);
      end
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL stall_release got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.out_valid); end
    beat(30'h0010000, 1'b1);
    checks++; if (bus.data_out !== 15'h0100) begin failures++; $display("FAIL stall_next got=%h want=0100", bus.data_out); end
    step();
  endtask

  task automatic test_reset_mid();
    beat(30'h0010000, 1'b0);
    beat(30'h0010000, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.beat_cnt !== 9'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.data_out !== 15'h0 || bus.sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_outputs got cnt=%0d v=%b rdy=%b d=%h s=%b want 0/0/1/0000/0", bus.beat_cnt, bus.out_valid, bus.in_ready, bus.data_out, bus.sat_flag);
    end
    step();
    rst_n = 1'b1;
    step();
    beat(30'h0000100, 1'b1);
    checks++; if (bus.data_out !== 15'h0001) begin failures++; $display("FAIL rstmid_residue got=%h want=0001", bus.data_out); end
    // Reset while holding a result in the output state.
    bus.out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.data_out !== 15'h0) begin failures++; $display("FAIL rstout got v=%b d=%h want v=0 d=0000", bus.out_valid, bus.data_out); end
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
  endtask

  task automatic test_forced_termination();
    for (int i = 0; i < 255; i++) begin
      beat(30'h0000100, 1'b0);
    end
    checks++; if (bus.beat_cnt !== 9'd255 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL force_pre got cnt=%0d v=%b want cnt=255 v=0", bus.beat_cnt, bus.out_valid); end
    beat(30'h0000100, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== 15'h0100 || bus.beat_cnt !== 9'd0 || bus.sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL force_end got v=%b d=%h cnt=%0d s=%b want v=1 d=0100 cnt=0 s=0", bus.out_valid, bus.data_out, bus.beat_cnt, bus.sat_flag);
    end
    step();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.prod_in   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    test_reset();
    test_ordinary();
    test_rounding();
    test_saturation();
    test_bubbles();
    test_back_to_back_stall();
    test_reset_mid();
    test_forced_termination();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
